// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the VGA sync/porch stage.
//   - default 640x480@60 timing
//   - count and watchdog widths
//   - lock_state_t for the frame lock FSM
//   - in_range(): inclusive unsigned range test on a count
package vga_pkg;

  localparam int DEF_TOTAL_COLS    = 800;
  localparam int DEF_TOTAL_ROWS    = 525;
  localparam int DEF_ACTIVE_COLS   = 640;
  localparam int DEF_ACTIVE_ROWS   = 480;
  localparam int DEF_H_FRONT_PORCH = 16;
  localparam int DEF_H_SYNC_WIDTH  = 96;
  localparam int DEF_V_FRONT_PORCH = 10;
  localparam int DEF_V_SYNC_WIDTH  = 2;
  localparam int DEF_VIDEO_WIDTH   = 3;

  localparam int CNT_W = 10;
  // Holds 2*800*525-1 for the default timing.
  localparam int WD_W  = 21;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;

  function automatic logic in_range(input logic [CNT_W-1:0] v,
                                    input logic [CNT_W-1:0] lo,
                                    input logic [CNT_W-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_sync_to_count.sv
// vga_sync_to_count: detects frame start on the upstream active-row flag
// and regenerates column/row counts that lag the upstream counts by 1 cycle.
// Ports:
//   i_Clk, i_Rst_L      pixel clock, synchronous active-low reset
//   i_VSync             upstream active-row flag
//   o_Col_Count         regenerated column count
//   o_Row_Count         regenerated row count
//   o_Frame_Start       combinational frame-start pulse (rising i_VSync)
module vga_sync_to_count
  import vga_pkg::*;
#(
  parameter int TOTAL_COLS = DEF_TOTAL_COLS,
  parameter int TOTAL_ROWS = DEF_TOTAL_ROWS
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  input  logic             i_VSync,
  output logic [CNT_W-1:0] o_Col_Count,
  output logic [CNT_W-1:0] o_Row_Count,
  output logic             o_Frame_Start
);

  localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(TOTAL_COLS - 1);
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(TOTAL_ROWS - 1);

  logic             r_VSync_d;
  logic [CNT_W-1:0] r_Col;
  logic [CNT_W-1:0] r_Row;

  // r_VSync_d resets high so a flag already high at reset release is not
  // mistaken for a frame start.
  assign o_Frame_Start = i_VSync & ~r_VSync_d;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_VSync_d <= 1'b1;
      r_Col     <= '0;
      r_Row     <= '0;
    end else begin
      r_VSync_d <= i_VSync;
      if (o_Frame_Start) begin
        r_Col <= '0;
        r_Row <= '0;
      end else if (r_Col == LAST_COL) begin
        r_Col <= '0;
        r_Row <= (r_Row == LAST_ROW) ? '0 : r_Row + 1'b1;
      end else begin
        r_Col <= r_Col + 1'b1;
      end
    end
  end

  assign o_Col_Count = r_Col;
  assign o_Row_Count = r_Row;

endmodule

// File: rtl/vga_sync_porch.sv
// vga_sync_porch: turns upstream active-region flags into active-low
// HSync/VSync with porches, locks to the incoming frame and delays video
// so sync and pixels leave aligned (both 2 cycles after upstream).
// Ports:
//   i_Clk, i_Rst_L            pixel clock, synchronous active-low reset
//   i_HSync, i_VSync          upstream active-column / active-row flags
//   i_Red, i_Grn, i_Blu       upstream video
//   o_HSync, o_VSync          active-low sync pulses
//   o_Red, o_Grn, o_Blu       delayed video
//   o_Col_Count, o_Row_Count  regenerated counts (1 cycle behind upstream)
//   o_Locked                  frame alignment acquired
//   o_Sync_Err                one-cycle pulse on an off-schedule frame start
// Build option: define VGA_PORCH_BLANK_EN to force video to 0 outside the
// active area; otherwise video passes through while locked.
module vga_sync_porch
  import vga_pkg::*;
#(
  parameter int TOTAL_COLS    = DEF_TOTAL_COLS,
  parameter int TOTAL_ROWS    = DEF_TOTAL_ROWS,
  parameter int ACTIVE_COLS   = DEF_ACTIVE_COLS,
  parameter int ACTIVE_ROWS   = DEF_ACTIVE_ROWS,
  parameter int H_FRONT_PORCH = DEF_H_FRONT_PORCH,
  parameter int H_SYNC_WIDTH  = DEF_H_SYNC_WIDTH,
  parameter int V_FRONT_PORCH = DEF_V_FRONT_PORCH,
  parameter int V_SYNC_WIDTH  = DEF_V_SYNC_WIDTH,
  parameter int VIDEO_WIDTH   = DEF_VIDEO_WIDTH
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_L,
  input  logic                   i_HSync,
  input  logic                   i_VSync,
  input  logic [VIDEO_WIDTH-1:0] i_Red,
  input  logic [VIDEO_WIDTH-1:0] i_Grn,
  input  logic [VIDEO_WIDTH-1:0] i_Blu,
  output logic                   o_HSync,
  output logic                   o_VSync,
  output logic [VIDEO_WIDTH-1:0] o_Red,
  output logic [VIDEO_WIDTH-1:0] o_Grn,
  output logic [VIDEO_WIDTH-1:0] o_Blu,
  output logic [CNT_W-1:0]       o_Col_Count,
  output logic [CNT_W-1:0]       o_Row_Count,
  output logic                   o_Locked,
  output logic                   o_Sync_Err
);

  localparam int PIX_W = 3 * VIDEO_WIDTH;

  localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(TOTAL_COLS - 1);
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(TOTAL_ROWS - 1);
  localparam logic [CNT_W-1:0] HS_LO    = CNT_W'(ACTIVE_COLS + H_FRONT_PORCH);
  localparam logic [CNT_W-1:0] HS_HI    = CNT_W'(ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH - 1);
  localparam logic [CNT_W-1:0] VS_LO    = CNT_W'(ACTIVE_ROWS + V_FRONT_PORCH);
  localparam logic [CNT_W-1:0] VS_HI    = CNT_W'(ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH - 1);
  // Two frames without a frame start drops lock.
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(2 * TOTAL_COLS * TOTAL_ROWS - 1);

  lock_state_t      r_State, w_State_Nxt;
  logic [WD_W-1:0]  r_Wd;
  logic [CNT_W-1:0] w_Col, w_Row;
  logic             w_FS, w_At_End, w_Locked, w_Wd_Expire, w_Vid_En;
  logic             r_HSync, r_VSync, r_Sync_Err;
  logic [PIX_W-1:0] w_Pix_In, r_Pix1, r_Pix2;
  logic             w_unused_hsync;

  // The column flag carries no information beyond the regenerated count.
  assign w_unused_hsync = i_HSync;

  vga_sync_to_count #(
    .TOTAL_COLS (TOTAL_COLS),
    .TOTAL_ROWS (TOTAL_ROWS)
  ) u_cnt (
    .i_Clk         (i_Clk),
    .i_Rst_L       (i_Rst_L),
    .i_VSync       (i_VSync),
    .o_Col_Count   (w_Col),
    .o_Row_Count   (w_Row),
    .o_Frame_Start (w_FS)
  );

  // Counts still hold the previous cycle's position when FS is seen, so a
  // scheduled frame start sees the last pixel of the frame here.
  assign w_At_End    = (w_Col == LAST_COL) && (w_Row == LAST_ROW);
  assign w_Locked    = (r_State == LOCKED);
  assign w_Wd_Expire = w_Locked && (r_Wd == WD_LAST);

  always_comb begin
    w_State_Nxt = r_State;
    if (r_State == SEARCH) begin
      if (w_FS) w_State_Nxt = LOCKED;
    end else begin
      // A frame start on the expiry cycle keeps the lock.
      if (w_Wd_Expire && !w_FS) w_State_Nxt = SEARCH;
    end
  end

`ifdef VGA_PORCH_BLANK_EN
  assign w_Vid_En = w_Locked && (w_Col < CNT_W'(ACTIVE_COLS)) && (w_Row < CNT_W'(ACTIVE_ROWS));
`else
  assign w_Vid_En = w_Locked;
`endif

  assign w_Pix_In = {i_Red, i_Grn, i_Blu};

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_State    <= SEARCH;
      r_Wd       <= '0;
      r_Sync_Err <= 1'b0;
      r_HSync    <= 1'b1;
      r_VSync    <= 1'b1;
      r_Pix1     <= '0;
      r_Pix2     <= '0;
    end else begin
      r_State    <= w_State_Nxt;
      r_Wd       <= (w_FS || !w_Locked || w_Wd_Expire) ? '0 : r_Wd + 1'b1;
      r_Sync_Err <= w_Locked && w_FS && !w_At_End;
      // Decoding the registered counts adds the second cycle of latency,
      // matching the second video stage below.
      r_HSync    <= !(w_Locked && in_range(w_Col, HS_LO, HS_HI));
      r_VSync    <= !(w_Locked && in_range(w_Row, VS_LO, VS_HI));
      r_Pix1     <= w_Pix_In;
      r_Pix2     <= w_Vid_En ? r_Pix1 : '0;
    end
  end

  assign o_HSync     = r_HSync;
  assign o_VSync     = r_VSync;
  assign {o_Red, o_Grn, o_Blu} = r_Pix2;
  assign o_Col_Count = w_Col;
  assign o_Row_Count = w_Row;
  assign o_Locked    = w_Locked;
  assign o_Sync_Err  = r_Sync_Err;

endmodule

// File: tb/tb_vga_sync_porch.sv
// Bench for vga_sync_porch with a reduced frame so lock, error and
// watchdog behaviour all fit in a short run.
module tb_vga_sync_porch;

  localparam int TC  = 40;
  localparam int TR  = 20;
  localparam int AC  = 24;
  localparam int AR  = 12;
  localparam int HFP = 4;
  localparam int HSW = 6;
  localparam int VFP = 2;
  localparam int VSW = 2;
  localparam int VW  = 3;
  localparam int FR  = TC * TR;
  localparam int WD  = 2 * FR;
  localparam int HS_LO = AC + HFP;
  localparam int HS_HI = AC + HFP + HSW - 1;
  localparam int VS_LO = AR + VFP;
  localparam int VS_HI = AR + VFP + VSW - 1;

  logic          gclk;
  logic          i_Rst_L, i_HSync, i_VSync;
  logic [VW-1:0] i_Red, i_Grn, i_Blu;
  logic          o_HSync, o_VSync, o_Locked, o_Sync_Err;
  logic [VW-1:0] o_Red, o_Grn, o_Blu;
  logic [9:0]    o_Col_Count, o_Row_Count;

  vga_sync_porch #(
    .TOTAL_COLS(TC), .TOTAL_ROWS(TR), .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR),
    .H_FRONT_PORCH(HFP), .H_SYNC_WIDTH(HSW), .V_FRONT_PORCH(VFP),
    .V_SYNC_WIDTH(VSW), .VIDEO_WIDTH(VW)
  ) dut (
    .i_Clk(gclk), .i_Rst_L(i_Rst_L), .i_HSync(i_HSync), .i_VSync(i_VSync),
    .i_Red(i_Red), .i_Grn(i_Grn), .i_Blu(i_Blu),
    .o_HSync(o_HSync), .o_VSync(o_VSync),
    .o_Red(o_Red), .o_Grn(o_Grn), .o_Blu(o_Blu),
    .o_Col_Count(o_Col_Count), .o_Row_Count(o_Row_Count),
    .o_Locked(o_Locked), .o_Sync_Err(o_Sync_Err)
  );

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  typedef struct { int col; int row; logic lk; logic err; } cnt_t;
  typedef struct { logic hs; logic vs; logic [8:0] rgb; } vid_t;

  cnt_t qc[$];
  vid_t qv[$];

  int n_tests, n_fail;
  int ucol, urow;
  bit jump_req, stop_mode, coin_mode;
  // reference model state
  logic m_prev_vs, m_lk;
  int   m_col, m_row, m_since, m_errs, obs_errs;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One pixel clock: check what is due, then drive the next upstream pixel
  // and push the outputs it must produce.
  task automatic step(input logic rst_l);
    cnt_t c;
    vid_t v;
    logic vs, fs, err;
    logic [8:0] pix;
    @(negedge gclk);
    if (qc.size() >= 1) begin
      c = qc.pop_front();
      chk("locked",   32'(o_Locked),    32'(c.lk));
      chk("sync_err", 32'(o_Sync_Err),  32'(c.err));
      chk("col",      32'(o_Col_Count), 32'(c.col));
      chk("row",      32'(o_Row_Count), 32'(c.row));
    end
    if (qv.size() >= 2) begin
      v = qv.pop_front();
      chk("hsync", 32'(o_HSync), 32'(v.hs));
      chk("vsync", 32'(o_VSync), 32'(v.vs));
      chk("rgb",   32'({o_Red, o_Grn, o_Blu}), 32'(v.rgb));
    end
    if (o_Sync_Err === 1'b1) obs_errs++;

    if (jump_req && ucol == 0 && urow == AR + 3) begin
      ucol = 0; urow = 0; jump_req = 0;
    end
    if (coin_mode && rst_l && m_lk && m_since == WD - 1) begin
      ucol = 0; urow = 0; coin_mode = 0;
    end
    vs  = (urow < AR) && !stop_mode && !coin_mode;
    pix = 9'($urandom);

    if (!rst_l) begin
      m_prev_vs = 1'b1; m_lk = 1'b0; m_since = 0; m_col = 0; m_row = 0;
      c = '{col: 0, row: 0, lk: 1'b0, err: 1'b0};
      v = '{hs: 1'b1, vs: 1'b1, rgb: 9'd0};
      if (qv.size() > 0) qv[$] = v;
    end else begin
      fs  = vs && !m_prev_vs;
      err = m_lk && fs && !(m_col == TC - 1 && m_row == TR - 1);
      if (err) m_errs++;
      if (fs) begin
        m_col = 0; m_row = 0;
      end else if (m_col == TC - 1) begin
        m_col = 0; m_row = (m_row == TR - 1) ? 0 : m_row + 1;
      end else m_col++;
      if (fs) begin
        m_lk = 1'b1; m_since = 0;
      end else if (m_lk) begin
        m_since++;
        if (m_since == WD) begin m_lk = 1'b0; m_since = 0; end
      end
      m_prev_vs = vs;
      c = '{col: m_col, row: m_row, lk: m_lk, err: err};
      if (m_lk) begin
        v.hs  = !(m_col >= HS_LO && m_col <= HS_HI);
        v.vs  = !(m_row >= VS_LO && m_row <= VS_HI);
        v.rgb = pix;
`ifdef VGA_PORCH_BLANK_EN
        if (m_col >= AC || m_row >= AR) v.rgb = 9'd0;
`endif
      end else v = '{hs: 1'b1, vs: 1'b1, rgb: 9'd0};
    end
    qc.push_back(c);
    qv.push_back(v);

    i_Rst_L = rst_l;
    i_VSync = vs;
    i_HSync = (ucol < AC);
    {i_Red, i_Grn, i_Blu} = pix;

    if (ucol == TC - 1) begin
      ucol = 0; urow = (urow == TR - 1) ? 0 : urow + 1;
    end else ucol++;
  endtask

  initial begin
    n_tests = 0; n_fail = 0; m_errs = 0; obs_errs = 0;
    ucol = 0; urow = 0; jump_req = 0; stop_mode = 0; coin_mode = 0;
    m_prev_vs = 1'b1; m_lk = 1'b0; m_col = 0; m_row = 0; m_since = 0;
    i_Rst_L = 1'b0; i_VSync = 1'b1; i_HSync = 1'b1;
    i_Red = '0; i_Grn = '0; i_Blu = '0;

    // reset held with the row flag already high, then lock on next frame
    repeat (5) step(1'b0);
    repeat (2 * FR + 100) step(1'b1);

    // early frame start from a blanking row
    jump_req = 1;
    while (jump_req) step(1'b1);
    repeat (2 * FR) step(1'b1);

    // row flag stuck low: watchdog drops lock, then relock
    stop_mode = 1;
    repeat (WD + 400) step(1'b1);
    stop_mode = 0;
    repeat (FR + 100) step(1'b1);

    // frame start landing on the watchdog expiry cycle
    coin_mode = 1;
    for (int i = 0; i < 4 * FR && coin_mode; i++) step(1'b1);
    chk("coin_trigger", 32'(coin_mode), 32'd0);
    coin_mode = 0;
    repeat (FR) step(1'b1);

    // reset mid-frame while the row flag is high
    while (urow != 3) step(1'b1);
    repeat (3) step(1'b0);
    repeat (2 * FR) step(1'b1);
    repeat (3) step(1'b1);

    chk("err_pulses", 32'(obs_errs), 32'(m_errs));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
